vga_frame_checker: RTL and testbench

VGA_FRAME_CHECKER -- requirements
Module: vga_frame_checker

---
 rtl/vga_frame_checker_pkg.sv | 13 +
 rtl/ref_pixel_fifo.sv | 46 ++++
 rtl/vga_frame_checker.sv | 145 ++++++++++++++
 tb/tb_vga_frame_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_checker_pkg.sv
// vga_frame_checker_pkg: shared FSM state type and default checker geometry.
package vga_frame_checker_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CHECK, S_DONE, S_HALT} state_t;
  localparam int DEF_NUM_CH         = 3;
  localparam int DEF_CH_WIDTH       = 10;
  localparam int DEF_REF_WIDTH      = 8;
  localparam int DEF_AREA_LEFT      = 160;
  localparam int DEF_AREA_RIGHT     = 480;
  localparam int DEF_AREA_TOP       = 120;
  localparam int DEF_AREA_BOTTOM    = 360;
  localparam int DEF_MAX_MISMATCHES = 10;
  localparam int DEF_FIFO_DEPTH     = 4;
endpackage

// File: rtl/ref_pixel_fifo.sv
// ref_pixel_fifo: reference pixel queue; when empty, a simultaneous push and pop
// passes din straight through to dout.
module ref_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             Clock_50,
  input  logic             Resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop) & ~(empty & pop);
  assign dout    = empty ? din : mem[rd_ptr];
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge Clock_50)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: compares displayed VGA pixels inside a window against a
// streamed reference frame, counting mismatching channels.
module vga_frame_checker
  import vga_frame_checker_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CH_WIDTH       = DEF_CH_WIDTH,
  parameter int REF_WIDTH      = DEF_REF_WIDTH,
  parameter int AREA_LEFT      = DEF_AREA_LEFT,
  parameter int AREA_RIGHT     = DEF_AREA_RIGHT,
  parameter int AREA_TOP       = DEF_AREA_TOP,
  parameter int AREA_BOTTOM    = DEF_AREA_BOTTOM,
  parameter int MAX_MISMATCHES = DEF_MAX_MISMATCHES,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                          Clock_50,
  input  logic                          Resetn,
  input  logic                          start_i,
  input  logic                          vsync_n_i,
  input  logic                          pixel_valid_i,
  input  logic [9:0]                    pixel_x_i,
  input  logic [9:0]                    pixel_y_i,
  input  logic [NUM_CH*CH_WIDTH-1:0]    pixel_i,
  input  logic                          ref_valid_i,
  input  logic [NUM_CH*REF_WIDTH-1:0]   ref_data_i,
  output logic                          ref_ready_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          halted_o,
  output logic                          incomplete_o,
  output logic                          underflow_o,
  output logic [15:0]                   mismatch_count_o,
  output logic [9:0]                    first_x_o,
  output logic [9:0]                    first_y_o,
  output logic [NUM_CH-1:0]             first_mask_o
);
  if (CH_WIDTH < REF_WIDTH) begin : g_width_err
    $error("CH_WIDTH must not be smaller than REF_WIDTH");
  end
  state_t state, state_nx;
  logic clear, checking, push, pop, full, empty, avail, cmp, at_last, upd, over, early_end;
  logic [NUM_CH*REF_WIDTH-1:0] ref_q;
  logic [NUM_CH-1:0] mask, stg_mask;
  logic stg_v, stg_last;
  logic [9:0] stg_x, stg_y;
  logic [15:0] pop_cnt, cnt_nx;
  logic [16:0] sum;
  assign busy_o      = state inside {S_ARM, S_SYNC, S_CHECK};
  assign done_o      = state == S_DONE;
  assign halted_o    = state == S_HALT;
  assign checking    = state == S_CHECK;
  assign clear       = start_i & ~busy_o;
  assign ref_ready_o = busy_o & ~full;
  assign push        = ref_valid_i & ref_ready_o;
  assign cmp = checking & pixel_valid_i
             & pixel_x_i >= 10'(AREA_LEFT) & pixel_x_i < 10'(AREA_RIGHT)
             & pixel_y_i >= 10'(AREA_TOP) & pixel_y_i < 10'(AREA_BOTTOM);
  assign at_last = cmp & pixel_x_i == 10'(AREA_RIGHT - 1) & pixel_y_i == 10'(AREA_BOTTOM - 1);
  assign avail   = ~empty | push;
  assign pop     = cmp & avail;
  assign upd     = checking & stg_v;
  ref_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(NUM_CH*REF_WIDTH)) u_fifo (
    .Clock_50(Clock_50),
    .Resetn(Resetn),
    .flush(clear),
    .push(push),
    .pop(pop),
    .din(ref_data_i),
    .dout(ref_q),
    .full(full),
    .empty(empty)
  );
  // Reference bytes are left-aligned into the wider display channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign mask[i] = pixel_i[(NUM_CH-1-i)*CH_WIDTH +: CH_WIDTH]
                  != (CH_WIDTH'(ref_q[(NUM_CH-1-i)*REF_WIDTH +: REF_WIDTH]) << (CH_WIDTH - REF_WIDTH));
  end
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) pop_cnt = pop_cnt + 16'(stg_mask[i]);
    sum    = {1'b0, mismatch_count_o} + {1'b0, pop_cnt};
    cnt_nx = !upd ? mismatch_count_o : sum[16] ? '1 : sum[15:0];
    over   = cnt_nx > 16'(MAX_MISMATCHES);
  end
  // Limit overrun beats end-of-area, which beats an early vsync.
  always_comb begin
    state_nx  = state;
    early_end = 1'b0;
    case (state)
      S_ARM:   state_nx = vsync_n_i ? S_ARM : S_SYNC;
      S_SYNC:  state_nx = vsync_n_i ? S_CHECK : S_SYNC;
      S_CHECK: begin
        state_nx  = over ? S_HALT : (stg_last || !vsync_n_i) ? S_DONE : S_CHECK;
        early_end = !over && !stg_last && !vsync_n_i;
      end
      default: state_nx = start_i ? S_ARM : state;
    endcase
  end
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) begin
      stg_v    <= 1'b0;
      stg_last <= 1'b0;
      stg_mask <= '0;
      stg_x    <= '0;
      stg_y    <= '0;
    end else if (clear) begin
      stg_v    <= 1'b0;
      stg_last <= 1'b0;
    end else begin
      stg_v    <= pop;
      stg_last <= at_last;
      stg_mask <= mask;
      stg_x    <= pixel_x_i;
      stg_y    <= pixel_y_i;
    end
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) begin
      state            <= S_IDLE;
      mismatch_count_o <= '0;
      first_x_o        <= '0;
      first_y_o        <= '0;
      first_mask_o     <= '0;
      incomplete_o     <= 1'b0;
      underflow_o      <= 1'b0;
    end else begin
      state <= state_nx;
      if (clear) begin
        mismatch_count_o <= '0;
        first_x_o        <= '0;
        first_y_o        <= '0;
        first_mask_o     <= '0;
        incomplete_o     <= 1'b0;
        underflow_o      <= 1'b0;
      end else begin
        mismatch_count_o <= cnt_nx;
        if (upd && mismatch_count_o == '0 && |stg_mask) begin
          first_x_o    <= stg_x;
          first_y_o    <= stg_y;
          first_mask_o <= stg_mask;
        end
        if (early_end) incomplete_o <= 1'b1;
        if (cmp && !avail) underflow_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: directed frames with a queued reference source; a monitor
// scores the final status of each frame against expectations queued up front.
module tb_vga_frame_checker;
  import vga_frame_checker_pkg::*;
  logic Clock_50, Resetn, start_i, vsync_n_i, pixel_valid_i, ref_valid_i, ref_ready_o;
  logic [9:0] pixel_x_i, pixel_y_i, first_x_o, first_y_o;
  logic [29:0] pixel_i;
  logic [23:0] ref_data_i;
  logic busy_o, done_o, halted_o, incomplete_o, underflow_o;
  logic [15:0] mismatch_count_o;
  logic [2:0] first_mask_o;
  logic stall;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic done, halted, inc, und;
    logic [15:0] cnt;
    logic [9:0] fx, fy;
    logic [2:0] fm;
  } res_t;
  res_t expq[$];
  logic [23:0] refq[$];

  vga_frame_checker dut (
    .Clock_50(Clock_50), .Resetn(Resetn), .start_i(start_i), .vsync_n_i(vsync_n_i),
    .pixel_valid_i(pixel_valid_i), .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .pixel_i(pixel_i), .ref_valid_i(ref_valid_i), .ref_data_i(ref_data_i),
    .ref_ready_o(ref_ready_o), .busy_o(busy_o), .done_o(done_o), .halted_o(halted_o),
    .incomplete_o(incomplete_o), .underflow_o(underflow_o),
    .mismatch_count_o(mismatch_count_o), .first_x_o(first_x_o), .first_y_o(first_y_o),
    .first_mask_o(first_mask_o)
  );

  initial Clock_50 = 1'b0;
  always #10 Clock_50 = ~Clock_50;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pat(input int x, input int y);
    logic [7:0] r, g;
    r = 8'(x);
    g = 8'(y);
    return {r, g, r ^ g};
  endfunction

  function automatic logic [29:0] expand(input logic [23:0] d);
    return {d[23:16], 2'b00, d[15:8], 2'b00, d[7:0], 2'b00};
  endfunction

  function automatic res_t mk(input logic d, input logic h, input logic inc, input logic und,
                              input logic [15:0] c, input logic [9:0] fx, input logic [9:0] fy,
                              input logic [2:0] fm);
    res_t r;
    r.done = d; r.halted = h; r.inc = inc; r.und = und;
    r.cnt = c; r.fx = fx; r.fy = fy; r.fm = fm;
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({ref_ready_o, busy_o, done_o, halted_o, incomplete_o, underflow_o,
                mismatch_count_o, first_x_o, first_y_o, first_mask_o});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input int x, input int y, input logic [29:0] p);
    @(negedge Clock_50);
    pixel_valid_i = 1'b1;
    pixel_x_i = 10'(x);
    pixel_y_i = 10'(y);
    pixel_i = p;
  endtask

  task automatic idle_px();
    @(negedge Clock_50);
    pixel_valid_i = 1'b0;
  endtask

  task automatic begin_frame();
    @(negedge Clock_50);
    start_i = 1'b1;
    @(negedge Clock_50);
    start_i = 1'b0;
    vsync_n_i = 1'b0;
    @(negedge Clock_50);
    vsync_n_i = 1'b1;
    repeat (4) @(negedge Clock_50);
  endtask

  task automatic wait_sb(input int n);
    int k;
    k = 0;
    while (expq.size() != 0 && k < n) begin
      @(negedge Clock_50);
      k++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL frame_end_timeout: %0d results pending, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Reference source: presents the queue head just after each falling edge.
  initial begin
    ref_valid_i = 1'b0;
    ref_data_i = '0;
    forever begin
      @(negedge Clock_50);
      #1;
      ref_valid_i = !stall && refq.size() != 0;
      ref_data_i = ref_valid_i ? refq[0] : '0;
      if (ref_valid_i && ref_ready_o) void'(refq.pop_front());
    end
  end

  // Monitor: scores each frame when done_o or halted_o rises.
  initial begin
    logic fin_q;
    res_t r;
    fin_q = 1'b0;
    forever begin
      @(negedge Clock_50);
      if ((done_o || halted_o) && !fin_q) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: got done=%0b halted=%0b, required no frame end", done_o, halted_o);
        end else begin
          r = expq.pop_front();
          chk("done", 64'(done_o), 64'(r.done));
          chk("halted", 64'(halted_o), 64'(r.halted));
          chk("incomplete", 64'(incomplete_o), 64'(r.inc));
          chk("underflow", 64'(underflow_o), 64'(r.und));
          chk("count", 64'(mismatch_count_o), 64'(r.cnt));
          chk("first_x", 64'(first_x_o), 64'(r.fx));
          chk("first_y", 64'(first_y_o), 64'(r.fy));
          chk("first_mask", 64'(first_mask_o), 64'(r.fm));
        end
      end
      fin_q = done_o || halted_o;
    end
  end

  initial begin
    logic [23:0] r;
    logic [29:0] p;
    Resetn = 1'b0; start_i = 1'b0; vsync_n_i = 1'b1; pixel_valid_i = 1'b0;
    pixel_x_i = '0; pixel_y_i = '0; pixel_i = '0; stall = 1'b0;
    repeat (3) @(negedge Clock_50);
    chk("reset_outputs", outs(), 64'd0);
    Resetn = 1'b1;

    // Matching full window.
    for (int y = 120; y < 360; y++)
      for (int x = 160; x < 480; x++) refq.push_back(pat(x, y));
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0, 10'd0, 3'b000));
    begin_frame();
    for (int y = 120; y < 360; y++)
      for (int x = 160; x < 480; x++) drv(x, y, expand(pat(x, y)));
    idle_px();
    wait_sb(50);

    // Green wrong at (200,130); stray pixels outside the window; ignored start.
    refq.delete();
    for (int x = 190; x <= 210; x++) begin
      r = pat(x, 130);
      if (x == 200) r[15:8] = 8'h40;
      refq.push_back(r);
    end
    refq.push_back(pat(479, 359));
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 10'd200, 10'd130, 3'b010));
    begin_frame();
    drv(100, 130, '0); drv(159, 130, '0); drv(480, 130, '0); drv(200, 119, '0); drv(200, 360, '0);
    for (int x = 190; x <= 210; x++) begin
      r = pat(x, 130);
      p = expand(r);
      if (x == 200) begin
        r[15:8] = 8'h40;
        p = expand(r);
        p[19:10] = 10'h104;
      end
      drv(x, 130, p);
      if (x == 201) chk("latency_1cycle", 64'(mismatch_count_o), 64'd0);
      if (x == 202) chk("latency_2cycle", 64'(mismatch_count_o), 64'd1);
      start_i = (x == 205);
    end
    drv(479, 359, expand(pat(479, 359)));
    idle_px();
    wait_sb(50);

    // All channels wrong from the window origin: halts after the 4th pixel.
    refq.delete();
    for (int i = 0; i < 10; i++) refq.push_back(pat(160 + i, 120));
    expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd12, 10'd160, 10'd120, 3'b111));
    begin_frame();
    for (int i = 0; i < 10; i++) begin
      drv(160 + i, 120, ~expand(pat(160 + i, 120)));
      if (i == 4) chk("halt_not_yet", 64'(halted_o), 64'd0);
      if (i == 5) chk("halt_after_4th", 64'(halted_o), 64'd1);
    end
    idle_px();
    wait_sb(50);

    // Reference stall: drained FIFO underflows, skipped bad pixels not counted.
    refq.delete();
    for (int i = 0; i < 200; i++) refq.push_back(24'h123456);
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 10'd0, 10'd0, 3'b000));
    begin_frame();
    for (int i = 0; i < 80; i++) begin
      drv(160 + i, 120, (i >= 36 && i < 50) ? 30'h3FFFFFFF : expand(24'h123456));
      stall = i >= 30 && i < 50;
    end
    stall = 1'b0;
    drv(479, 359, expand(24'h123456));
    idle_px();
    wait_sb(50);

    // Early vsync at row 200.
    refq.delete();
    for (int i = 0; i < 10; i++) refq.push_back(pat(160 + i, 199));
    refq.push_back(pat(160, 200));
    expq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 10'd0, 10'd0, 3'b000));
    begin_frame();
    for (int i = 0; i < 10; i++) drv(160 + i, 199, expand(pat(160 + i, 199)));
    drv(160, 200, expand(pat(160, 200)));
    vsync_n_i = 1'b0;
    idle_px();
    wait_sb(20);
    vsync_n_i = 1'b1;

    // Reset asserted mid-check.
    refq.delete();
    for (int i = 0; i < 5; i++) refq.push_back(pat(160 + i, 121));
    begin_frame();
    drv(160, 121, ~expand(pat(160, 121)));
    drv(161, 121, expand(pat(161, 121)));
    drv(162, 121, expand(pat(162, 121)));
    idle_px();
    @(negedge Clock_50);
    chk("pre_reset_count", 64'(mismatch_count_o), 64'd3);
    chk("pre_reset_busy", 64'(busy_o), 64'd1);
    #3 Resetn = 1'b0;
    #1;
    chk("mid_reset_outputs", outs(), 64'd0);
    chk("mid_reset_state", 64'(dut.state), 64'(S_IDLE));
    @(negedge Clock_50);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock_50);
    chk("post_reset_outputs", outs(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
